// File: rtl/phys_mem_ctrl_pkg.sv
// Shared definitions for the physical SRAM controller: FSM encoding, default
// wait states and address-decode helpers.
package phys_mem_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_WAIT  = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4,
    ST_UNMAP    = 3'd5
  } state_t;

  localparam int DEF_READ_WAIT   = 2;
  localparam int DEF_WRITE_WAIT  = 3;
  localparam int DEF_SRAM_ADDR_W = 20;
  localparam int CNT_W           = 8;

  // Bank select sits just above the word address within the byte address.
  function automatic int bank_bit(input int addr_w);
    return addr_w + 2;
  endfunction

  // Every byte-address bit above the bank select is unmapped.
  function automatic logic [31:0] unmap_mask(input int addr_w);
    return 32'hFFFF_FFFF << (addr_w + 3);
  endfunction

endpackage

// File: rtl/phys_mem_ctrl.sv
// Word-access responder for two asynchronous 32-bit SRAM banks with
// programmable read/write strobe widths and a one-entry read-result register.
module phys_mem_ctrl
  import phys_mem_ctrl_pkg::*;
#(
  parameter int READ_WAIT   = DEF_READ_WAIT,
  parameter int WRITE_WAIT  = DEF_WRITE_WAIT,
  parameter int SRAM_ADDR_W = DEF_SRAM_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            dev_mem_addr,
  input  logic [31:0]            dev_mem_wdata,
  input  logic                   dev_mem_is_write,
  output logic [31:0]            dev_mem_rdata,
  output logic                   dev_mem_busy,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [31:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [31:0]            sram_dq_in,
  output logic                   baseram_ce_n,
  output logic                   extram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n
);

  localparam int          BANK_BIT   = bank_bit(SRAM_ADDR_W);
  localparam logic [31:0] UNMAP_MASK = unmap_mask(SRAM_ADDR_W);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:2]      addr_reg, last_addr_reg;
  logic [31:0]      wdata_reg, rdata_reg;
  logic             bank_reg, is_write_reg, last_valid_reg, wr_done_reg;
  logic             oe_n_reg, we_n_reg, base_ce_n_reg, ext_ce_n_reg, dq_oe_reg;
  logic             oe_n_next, we_n_next, base_ce_n_next, ext_ce_n_next, dq_oe_next;

  logic req_unmapped, req_bank, addr_match, wdata_match;
  logic wr_req, rd_req, new_req, sel_bank, in_rd, in_wr;
  logic unused_addr_lsbs;

  // Byte offset within a word carries no meaning for word accesses.
  assign unused_addr_lsbs = ^dev_mem_addr[1:0];

  assign req_unmapped = |(dev_mem_addr & UNMAP_MASK);
  assign req_bank     = dev_mem_addr[BANK_BIT];
  assign addr_match   = (dev_mem_addr[31:2] == addr_reg);
  assign wdata_match  = (dev_mem_wdata == wdata_reg);

  // A repeated write is suppressed only while the CPU keeps presenting the
  // exact same write; any change re-arms it in the same cycle (no idle gap).
  assign wr_req  = dev_mem_is_write && !(wr_done_reg && addr_match && wdata_match);
  assign rd_req  = !dev_mem_is_write && (!last_valid_reg || (dev_mem_addr[31:2] != last_addr_reg));
  assign new_req = rst && (state_reg == ST_IDLE) && (wr_req || rd_req);

  assign dev_mem_busy  = (state_reg != ST_IDLE) || new_req;
  assign dev_mem_rdata = rdata_reg;
  assign sram_addr     = addr_reg[SRAM_ADDR_W+1:2];
  assign sram_dq_out   = wdata_reg;
  assign sram_dq_oe    = dq_oe_reg;
  assign baseram_ce_n  = base_ce_n_reg;
  assign extram_ce_n   = ext_ce_n_reg;
  assign sram_oe_n     = oe_n_reg;
  assign sram_we_n     = we_n_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (new_req) begin
          if (req_unmapped) begin
            state_next = ST_UNMAP;
          end else if (dev_mem_is_write) begin
            state_next = ST_WR_SETUP;
          end else begin
            state_next = ST_RD_WAIT;
            cnt_next   = CNT_W'(READ_WAIT - 1);
          end
        end
      end
      ST_RD_WAIT: begin
        if (cnt_reg == '0) state_next = ST_IDLE;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      ST_WR_SETUP: begin
        state_next = ST_WR_PULSE;
        cnt_next   = CNT_W'(WRITE_WAIT - 1);
      end
      ST_WR_PULSE: begin
        if (cnt_reg == '0) state_next = ST_WR_HOLD;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      ST_WR_HOLD: state_next = ST_IDLE;
      ST_UNMAP:   state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase

    // Strobes are registered from the next state so the pins never glitch.
    sel_bank       = (state_reg == ST_IDLE) ? req_bank : bank_reg;
    in_rd          = (state_next == ST_RD_WAIT);
    in_wr          = state_next inside {ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD};
    oe_n_next      = !in_rd;
    we_n_next      = (state_next != ST_WR_PULSE);
    dq_oe_next     = in_wr;
    base_ce_n_next = !((in_rd || in_wr) && !sel_bank);
    ext_ce_n_next  = !((in_rd || in_wr) && sel_bank);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      oe_n_reg      <= 1'b1;
      we_n_reg      <= 1'b1;
      base_ce_n_reg <= 1'b1;
      ext_ce_n_reg  <= 1'b1;
      dq_oe_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      oe_n_reg      <= oe_n_next;
      we_n_reg      <= we_n_next;
      base_ce_n_reg <= base_ce_n_next;
      ext_ce_n_reg  <= ext_ce_n_next;
      dq_oe_reg     <= dq_oe_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_reg       <= '0;
      wdata_reg      <= '0;
      bank_reg       <= 1'b0;
      is_write_reg   <= 1'b0;
      last_addr_reg  <= '0;
      last_valid_reg <= 1'b0;
      wr_done_reg    <= 1'b0;
      rdata_reg      <= '0;
    end else begin
      if (new_req) begin
        addr_reg     <= dev_mem_addr[31:2];
        wdata_reg    <= dev_mem_wdata;
        bank_reg     <= req_bank;
        is_write_reg <= dev_mem_is_write;
      end
      if (state_reg == ST_RD_WAIT && cnt_reg == '0) begin
        rdata_reg      <= sram_dq_in;
        last_valid_reg <= 1'b1;
        last_addr_reg  <= addr_reg;
      end
      // Keep the read-result register coherent with a write to its address.
      if (state_reg == ST_WR_HOLD && last_valid_reg && last_addr_reg == addr_reg) begin
        rdata_reg <= wdata_reg;
      end
      if (state_reg == ST_UNMAP && !is_write_reg) begin
        rdata_reg      <= '0;
        last_valid_reg <= 1'b1;
        last_addr_reg  <= addr_reg;
      end
      if (!dev_mem_is_write || !addr_match || !wdata_match) begin
        wr_done_reg <= 1'b0;
      end else if (state_reg == ST_WR_HOLD || (state_reg == ST_UNMAP && is_write_reg)) begin
        wr_done_reg <= 1'b1;
      end
    end
  end

endmodule
